// File: rtl/multicycle_control_unit.sv
// ----------------------------------------------------------------------------
// multicycle_control_unit
//
// Moore FSM that sequences the 8-bit multicycle datapath through fetch,
// decode, execute, memory and writeback. It decodes the opcode in the
// instruction register and the {N,Z,C,V} flags, then drives every write
// strobe and mux select in the datapath. It also exports the current state
// code and a count of retired instructions.
//
// Instruction format: ir[15:12]=op, ir[11:10]=rd, ir[9:8]=rs, ir[7:0]=imm8.
//
// Optional feature: define MC_CTRL_MEM_WAIT_EN to add a memory handshake.
// This adds the input mem_ready and the output mem_req. FETCH, MEM_RD and
// MEM_WR then hold their state until mem_ready=1. When the macro is not
// defined, memory completes in one cycle.
//
// Ports
//   clock        in   1      system clock, rising edge
//   reset        in   1      synchronous, active-low
//   ir           in   16     instruction register contents
//   flags        in   4      {N,Z,C,V}
//   mem_ready    in   1      memory ready (MC_CTRL_MEM_WAIT_EN only)
//   mem_req      out  1      memory request (MC_CTRL_MEM_WAIT_EN only)
//   state        out  4      current FSM state code
//   pc_write     out  1      PC load strobe
//   pc_src       out  1      0 = PC+1, 1 = imm8
//   ir_write     out  1      IR load strobe
//   addr_sel     out  1      memory address: 0 = PC, 1 = imm8
//   mem_write    out  1      data memory write strobe
//   reg_write    out  1      register file write strobe
//   reg_wr_sel   out  2      0 = ALU, 1 = imm8, 2 = memory data
//   alu_ctrl     out  3      0 ADD, 1 SUB, 2 AND, 3 ORR, 4 XOR
//   flags_write  out  1      flag register load strobe
//   halted       out  1      high in HALT
//   instr_count  out  CNT_W  retired-instruction count (wraps)
// ----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int         CNT_W     = 16,
    parameter logic [3:0] HALT_CODE = 4'hF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [15:0]      ir,
    input  logic [3:0]       flags,
`ifdef MC_CTRL_MEM_WAIT_EN
    input  logic             mem_ready,
    output logic             mem_req,
`endif
    output logic [3:0]       state,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             addr_sel,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       reg_wr_sel,
    output logic [2:0]       alu_ctrl,
    output logic             flags_write,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] S_FETCH  = 4'h0;
    localparam logic [3:0] S_DECODE = 4'h1;
    localparam logic [3:0] S_ALU    = 4'h2;
    localparam logic [3:0] S_ALU_WB = 4'h3;
    localparam logic [3:0] S_LDI    = 4'h4;
    localparam logic [3:0] S_MEM_RD = 4'h5;
    localparam logic [3:0] S_MEM_WB = 4'h6;
    localparam logic [3:0] S_MEM_WR = 4'h7;
    localparam logic [3:0] S_BRANCH = 4'h8;
    localparam logic [3:0] S_HALT   = 4'h9;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;

    localparam logic [1:0] WR_ALU = 2'd0;
    localparam logic [1:0] WR_IMM = 2'd1;
    localparam logic [1:0] WR_MEM = 2'd2;

    logic [3:0]       state_q;
    logic [3:0]       state_d;
    logic [CNT_W-1:0] count_q;
    logic             count_en;
    logic [3:0]       op;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;

    // The register fields and the V flag are used by the datapath, not by this FSM.
    logic             sig_unused;

    assign op         = ir[15:12];
    assign flag_n     = flags[3];
    assign flag_z     = flags[2];
    assign flag_c     = flags[1];
    assign sig_unused = ^{ir[11:0], flags[0]};

    // Next state after DECODE. The HALT opcode is checked first so that a
    // non-default HALT_CODE takes priority over the fixed opcode map.
    function automatic logic [3:0] decode_next(input logic [3:0] opc);
        logic [3:0] nxt;
        if (opc == HALT_CODE) begin
            nxt = S_HALT;
        end else begin
            case (opc)
                4'h1:                      nxt = S_LDI;
                4'h2, 4'h3, 4'h4,
                4'h5, 4'h6, 4'h7:          nxt = S_ALU;
                4'h8:                      nxt = S_MEM_RD;
                4'h9:                      nxt = S_MEM_WR;
                4'hA, 4'hB, 4'hC,
                4'hD, 4'hE:                nxt = S_BRANCH;
                default:                   nxt = S_FETCH;
            endcase
        end
        return nxt;
    endfunction

    // ALU operation selected by the opcode. CMP (7) reuses SUB.
    function automatic logic [2:0] alu_op(input logic [3:0] opc);
        logic [2:0] ctl;
        case (opc)
            4'h3, 4'h7: ctl = ALU_SUB;
            4'h4:       ctl = ALU_AND;
            4'h5:       ctl = ALU_ORR;
            4'h6:       ctl = ALU_XOR;
            default:    ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

    // Decides whether a branch is taken, using the flags present in the BRANCH cycle.
    function automatic logic branch_taken(input logic [3:0] opc, input logic n,
                                          input logic z, input logic c);
        logic tk;
        case (opc)
            4'hA:    tk = 1'b1;
            4'hB:    tk = z;
            4'hC:    tk = ~z;
            4'hD:    tk = c;
            4'hE:    tk = n;
            default: tk = 1'b0;
        endcase
        return tk;
    endfunction

    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        ir_write    = 1'b0;
        addr_sel    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        reg_wr_sel  = WR_ALU;
        alu_ctrl    = ALU_ADD;
        flags_write = 1'b0;
        halted      = 1'b0;
`ifdef MC_CTRL_MEM_WAIT_EN
        mem_req     = 1'b0;
`endif

        case (state_q)
            S_FETCH: begin
                addr_sel = 1'b0;
`ifdef MC_CTRL_MEM_WAIT_EN
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
`else
                ir_write = 1'b1;
                pc_write = 1'b1;
                state_d  = S_DECODE;
`endif
            end
            S_DECODE: begin
                state_d = decode_next(op);
            end
            S_ALU: begin
                alu_ctrl    = alu_op(op);
                flags_write = 1'b1;
                state_d     = (op == 4'h7) ? S_FETCH : S_ALU_WB;
            end
            S_ALU_WB: begin
                // Keep the ALU operation stable while its result is written back.
                alu_ctrl   = alu_op(op);
                reg_write  = 1'b1;
                reg_wr_sel = WR_ALU;
                state_d    = S_FETCH;
            end
            S_LDI: begin
                reg_write  = 1'b1;
                reg_wr_sel = WR_IMM;
                state_d    = S_FETCH;
            end
            S_MEM_RD: begin
                addr_sel = 1'b1;
`ifdef MC_CTRL_MEM_WAIT_EN
                mem_req = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
`else
                state_d = S_MEM_WB;
`endif
            end
            S_MEM_WB: begin
                addr_sel   = 1'b1;
                reg_write  = 1'b1;
                reg_wr_sel = WR_MEM;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                addr_sel  = 1'b1;
                mem_write = 1'b1;
`ifdef MC_CTRL_MEM_WAIT_EN
                mem_req = 1'b1;
                if (mem_ready) state_d = S_FETCH;
`else
                state_d = S_FETCH;
`endif
            end
            S_BRANCH: begin
                pc_src   = 1'b1;
                pc_write = branch_taken(op, flag_n, flag_z, flag_c);
                state_d  = S_FETCH;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // While reset is asserted, force all outputs low so that an
        // instruction cut off by reset cannot make a partial write.
        if (!reset) begin
            pc_write    = 1'b0;
            pc_src      = 1'b0;
            ir_write    = 1'b0;
            addr_sel    = 1'b0;
            mem_write   = 1'b0;
            reg_write   = 1'b0;
            reg_wr_sel  = WR_ALU;
            alu_ctrl    = ALU_ADD;
            flags_write = 1'b0;
            halted      = 1'b0;
`ifdef MC_CTRL_MEM_WAIT_EN
            mem_req     = 1'b0;
`endif
        end
    end

    // An instruction retires when its last cycle hands control back to FETCH.
    // A DECODE->FETCH transition for NOP counts. HALT never reaches FETCH, so
    // a halted instruction is never counted.
    assign count_en = (state_q != S_FETCH) && (state_q != S_HALT) && (state_d == S_FETCH);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (count_en) count_q <= count_q + CNT_W'(1);
        end
    end

    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Directed bench for multicycle_control_unit. A single initial block steps
// through one instruction after another. The bench drives ir and flags as the
// datapath would and checks the state code, strobes, selects and the retired
// count after each clock edge against hand-computed values.
// ----------------------------------------------------------------------------
module tb_multicycle_control_unit;

    logic        clock;
    logic        reset;
    logic [15:0] ir;
    logic [3:0]  flags;
`ifdef MC_CTRL_MEM_WAIT_EN
    logic        mem_ready;
    logic        mem_req;
`endif
    logic [3:0]  state;
    logic        pc_write;
    logic        pc_src;
    logic        ir_write;
    logic        addr_sel;
    logic        mem_write;
    logic        reg_write;
    logic [1:0]  reg_wr_sel;
    logic [2:0]  alu_ctrl;
    logic        flags_write;
    logic        halted;
    logic [15:0] instr_count;

    int n_assert;
    int n_fail;
    int exp_cnt;

    multicycle_control_unit #(.CNT_W(16), .HALT_CODE(4'hF)) dut (
        .clock       (clock),
        .reset       (reset),
        .ir          (ir),
        .flags       (flags),
`ifdef MC_CTRL_MEM_WAIT_EN
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
`endif
        .state       (state),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .ir_write    (ir_write),
        .addr_sel    (addr_sel),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .reg_wr_sel  (reg_wr_sel),
        .alu_ctrl    (alu_ctrl),
        .flags_write (flags_write),
        .halted      (halted),
        .instr_count (instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        exp_cnt  = 0;
        reset    = 1'b0;
        ir       = 16'h0000;
        flags    = 4'b0000;
`ifdef MC_CTRL_MEM_WAIT_EN
        mem_ready = 1'b1;
`endif

        // Reset state: strobes are forced low while reset is held.
        tick();
        tick();
        chk("rst_state", state, 4'h0);
        chk("rst_count", instr_count, 16'd0);
        chk("rst_irw_forced", ir_write, 1'b0);
        chk("rst_pcw_forced", pc_write, 1'b0);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("fetch_irw", ir_write, 1'b1);
        chk("fetch_pcw", pc_write, 1'b1);
        chk("fetch_pcsrc", pc_src, 1'b0);
        chk("fetch_addr", addr_sel, 1'b0);

        // LDI R2,0x42: states 0,1,4,0.
        ir = 16'h1A42;
        tick();
        chk("ldi_s1", state, 4'h1);
        chk("ldi_dec_irw", ir_write, 1'b0);
        chk("ldi_dec_rw", reg_write, 1'b0);
        tick();
        chk("ldi_s4", state, 4'h4);
        chk("ldi_rw", reg_write, 1'b1);
        chk("ldi_sel", reg_wr_sel, 2'd1);
        tick();
        exp_cnt++;
        chk("ldi_s0", state, 4'h0);
        chk("ldi_cnt", instr_count, exp_cnt);

        // ADD interrupted by reset in the ALU state.
        ir = 16'h2100;
        tick();
        tick();
        chk("add_s2", state, 4'h2);
        chk("add_fw", flags_write, 1'b1);
        reset = 1'b0;
        #1;
        chk("mid_rst_fw", flags_write, 1'b0);
        chk("mid_rst_rw", reg_write, 1'b0);
        tick();
        chk("mid_rst_s0a", state, 4'h0);
        chk("mid_rst_rw_a", reg_write, 1'b0);
        tick();
        exp_cnt = 0;
        chk("mid_rst_s0b", state, 4'h0);
        chk("mid_rst_rw_b", reg_write, 1'b0);
        chk("mid_rst_cnt", instr_count, exp_cnt);
        reset = 1'b1;

        // CMP with Z set: 3 cycles, flags only, SUB.
        ir    = 16'h7100;
        flags = 4'b0100;
        tick();
        chk("cmp_s1", state, 4'h1);
        tick();
        chk("cmp_s2", state, 4'h2);
        chk("cmp_fw", flags_write, 1'b1);
        chk("cmp_alu", alu_ctrl, 3'd1);
        chk("cmp_rw", reg_write, 1'b0);
        tick();
        exp_cnt++;
        chk("cmp_s0", state, 4'h0);
        chk("cmp_cnt", instr_count, exp_cnt);

        // BEQ taken (Z=1).
        ir = 16'hB030;
        tick();
        tick();
        chk("beq_s8", state, 4'h8);
        chk("beq_pcw", pc_write, 1'b1);
        chk("beq_pcsrc", pc_src, 1'b1);
        tick();
        exp_cnt++;
        chk("beq_cnt", instr_count, exp_cnt);

        // BNE not taken (Z=1), but it still retires.
        ir = 16'hC030;
        tick();
        tick();
        chk("bne_s8", state, 4'h8);
        chk("bne_pcw", pc_write, 1'b0);
        chk("bne_pcsrc", pc_src, 1'b1);
        tick();
        exp_cnt++;
        chk("bne_s0", state, 4'h0);
        chk("bne_cnt", instr_count, exp_cnt);

        // BMI taken (N=1), BCS not taken (C=0).
        ir    = 16'hE030;
        flags = 4'b1000;
        tick();
        tick();
        chk("bmi_pcw", pc_write, 1'b1);
        tick();
        exp_cnt++;
        ir = 16'hD030;
        tick();
        tick();
        chk("bcs_pcw", pc_write, 1'b0);
        tick();
        exp_cnt++;
        chk("bcs_cnt", instr_count, exp_cnt);

        // AND: 4 cycles with writeback.
        ir = 16'h4300;
        tick();
        tick();
        chk("and_alu", alu_ctrl, 3'd2);
        chk("and_fw", flags_write, 1'b1);
        tick();
        chk("and_s3", state, 4'h3);
        chk("and_wb_rw", reg_write, 1'b1);
        chk("and_wb_sel", reg_wr_sel, 2'd0);
        chk("and_wb_alu", alu_ctrl, 3'd2);
        chk("and_wb_fw", flags_write, 1'b0);
        tick();
        exp_cnt++;
        chk("and_s0", state, 4'h0);
        chk("and_cnt", instr_count, exp_cnt);

        // XOR opcode maps to ALU code 4.
        ir = 16'h6500;
        tick();
        tick();
        chk("xor_alu", alu_ctrl, 3'd4);
        tick();
        tick();
        exp_cnt++;

        // LDR: 1,5,6,0.
        ir = 16'h8410;
        tick();
        tick();
        chk("ldr_s5", state, 4'h5);
        chk("ldr_addr", addr_sel, 1'b1);
        chk("ldr_rd_rw", reg_write, 1'b0);
        tick();
        chk("ldr_s6", state, 4'h6);
        chk("ldr_wb_rw", reg_write, 1'b1);
        chk("ldr_wb_sel", reg_wr_sel, 2'd2);
        chk("ldr_wb_addr", addr_sel, 1'b1);
        tick();
        exp_cnt++;
        chk("ldr_cnt", instr_count, exp_cnt);

        // STR: 1,7,0.
        ir = 16'h9410;
        tick();
        tick();
        chk("str_s7", state, 4'h7);
        chk("str_mw", mem_write, 1'b1);
        chk("str_addr", addr_sel, 1'b1);
        tick();
        exp_cnt++;
        chk("str_s0", state, 4'h0);
        chk("str_cnt", instr_count, exp_cnt);

        // NOP: 2 cycles.
        ir = 16'h0000;
        tick();
        chk("nop_s1", state, 4'h1);
        tick();
        exp_cnt++;
        chk("nop_s0", state, 4'h0);
        chk("nop_cnt", instr_count, exp_cnt);

        // HLT: stays in HALT for 20 cycles without counting.
        ir = 16'hF000;
        tick();
        tick();
        chk("hlt_s9", state, 4'h9);
        chk("hlt_halted", halted, 1'b1);
        for (int i = 0; i < 20; i++) tick();
        chk("hlt_hold_s9", state, 4'h9);
        chk("hlt_hold_halted", halted, 1'b1);
        chk("hlt_hold_pcw", pc_write, 1'b0);
        chk("hlt_cnt", instr_count, exp_cnt);
        reset = 1'b0;
        tick();
        exp_cnt = 0;
        chk("hlt_rst_s0", state, 4'h0);
        chk("hlt_rst_halted", halted, 1'b0);
        chk("hlt_rst_cnt", instr_count, exp_cnt);
        reset = 1'b1;

`ifdef MC_CTRL_MEM_WAIT_EN
        // FETCH waits for memory.
        #1;
        mem_ready = 1'b0;
        #1;
        chk("mw_fetch_req", mem_req, 1'b1);
        chk("mw_fetch_irw", ir_write, 1'b0);
        tick();
        chk("mw_fetch_hold", state, 4'h0);
        mem_ready = 1'b1;
        #1;
        chk("mw_fetch_irw_rdy", ir_write, 1'b1);

        // LDR with mem_ready low for 3 cycles: MEM_RD held for 4 cycles.
        ir = 16'h8010;
        tick();
        chk("mw_ldr_s1", state, 4'h1);
        mem_ready = 1'b0;
        tick();
        chk("mw_ldr_c1", state, 4'h5);
        chk("mw_ldr_req", mem_req, 1'b1);
        tick();
        chk("mw_ldr_c2", state, 4'h5);
        tick();
        chk("mw_ldr_c3", state, 4'h5);
        tick();
        chk("mw_ldr_c4", state, 4'h5);
        mem_ready = 1'b1;
        tick();
        chk("mw_ldr_s6", state, 4'h6);
        tick();
        exp_cnt++;
        chk("mw_ldr_s0", state, 4'h0);
        chk("mw_ldr_cnt", instr_count, exp_cnt);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
